// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the memory responder slice.
// Holds the FSM state encoding, the request-kind decode and the default geometry.
package mem_bus_pkg;

  localparam int DEF_ADDR_WIDTH  = 14;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_DEPTH       = 1024;
  localparam int DEF_WAIT_CYCLES = 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    HOLD
  } mem_state_t;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_READ,
    REQ_WRITE,
    REQ_ILLEGAL
  } req_kind_t;

  // Classify the raw cs/we/oe strobes into one request kind.
  function automatic req_kind_t decodeReq(input logic cs, input logic we, input logic oe);
    if (!cs) return REQ_NONE;
    if (we && oe) return REQ_ILLEGAL;
    if (we) return REQ_WRITE;
    if (oe) return REQ_READ;
    return REQ_NONE;
  endfunction

  // Storage index width; never narrower than one bit so a one-word array still elaborates.
  function automatic int idxWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Control/handshake bundle between the CPU (master) and the memory responder (slave).
// The bidirectional data bus is kept as a direct port on the responder so the
// tristate is resolved at a plain module boundary.
interface mem_responder_if
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] addr;
  logic                  cs;
  logic                  we;
  logic                  oe;
  logic                  ready;
  logic                  err;

  modport master (
    output addr, cs, we, oe,
    input  ready, err
  );

  modport slave (
    input  addr, cs, we, oe,
    output ready, err
  );

endinterface

// File: rtl/mem_responder_array.sv
// Word storage for the memory responder: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module mem_responder_array
  import mem_bus_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int IDX_W      = idxWidth(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_wrIdx,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  input  logic [IDX_W-1:0]      i_rdIdx,
  output logic [DATA_WIDTH-1:0] o_rdData
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Commit a write on the clock edge when the controller asks for it.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wrIdx] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdIdx];

endmodule

// File: rtl/mem_responder.sv
// Bus-side memory target: accepts cs/we/oe requests, inserts WAIT_CYCLES wait
// states, answers with a one-cycle ready (plus err for illegal or out-of-range
// requests) and drives the shared data bus only while returning read data.
// Optional build macro MEM_RESPONDER_STATS_EN adds saturating rd_count/wr_count outputs.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_responder_if.slave        bus,
  inout  wire [DATA_WIDTH-1:0]  data
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
`endif
);

  localparam int         IDX_W     = idxWidth(DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  mem_state_t            r_state;
  mem_state_t            w_nextState;
  req_kind_t             r_reqKind;
  req_kind_t             w_reqKind;
  logic [ADDR_WIDTH-1:0] r_reqAddr;
  logic                  r_reqWe;
  logic                  r_reqOe;
  logic [DATA_WIDTH-1:0] r_reqData;
  logic [3:0]            r_waitCnt;

  logic                  w_accept;
  logic                  w_held;
  logic                  w_inRange;
  logic                  w_ready;
  logic                  w_err;
  logic                  w_driveBus;
  logic                  w_memWe;
  logic [DATA_WIDTH-1:0] w_memRdData;
  logic [DATA_WIDTH-1:0] w_rdValue;

  assign w_reqKind = decodeReq(bus.cs, bus.we, bus.oe);

  // A request is "held" when the initiator keeps presenting the one just served.
  assign w_held = (bus.addr == r_reqAddr) && (bus.we == r_reqWe) && (bus.oe == r_reqOe);

  // Range check on the full latched address so high bits never alias into storage.
  assign w_inRange = (32'(r_reqAddr) < 32'(DEPTH));

  // State register; reset drops any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic, including request acceptance from IDLE or from HOLD.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_reqKind != REQ_NONE) w_accept = 1'b1;
      end
      WAIT: begin
        if (!bus.cs)              w_nextState = IDLE;
        else if (r_waitCnt <= 4'd1) w_nextState = RESP;
      end
      RESP: begin
        w_nextState = HOLD;
      end
      HOLD: begin
        if (!bus.cs)                                  w_nextState = IDLE;
        else if (!w_held && (w_reqKind != REQ_NONE))  w_accept = 1'b1;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    if (w_accept) begin
      w_nextState = ((w_reqKind == REQ_ILLEGAL) || (WAIT_CYCLES == 0)) ? RESP : WAIT;
    end
  end

  // Capture the accepted request so later bus changes cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reqKind <= REQ_NONE;
      r_reqAddr <= '0;
      r_reqWe   <= 1'b0;
      r_reqOe   <= 1'b0;
      r_reqData <= '0;
    end else if (w_accept) begin
      r_reqKind <= w_reqKind;
      r_reqAddr <= bus.addr;
      r_reqWe   <= bus.we;
      r_reqOe   <= bus.oe;
      if (w_reqKind == REQ_WRITE) r_reqData <= data;
    end
  end

  // Wait-state counter: loaded on accept, counts down while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waitCnt <= '0;
    end else if (w_accept) begin
      r_waitCnt <= WAIT_LOAD;
    end else if ((r_state == WAIT) && (r_waitCnt != 4'd0)) begin
      r_waitCnt <= r_waitCnt - 4'd1;
    end
  end

  // Response outputs are only active in the single RESP cycle.
  always_comb begin
    w_ready    = 1'b0;
    w_err      = 1'b0;
    w_driveBus = 1'b0;
    w_memWe    = 1'b0;
    if (r_state == RESP) begin
      w_ready = 1'b1;
      case (r_reqKind)
        REQ_READ: begin
          w_err      = !w_inRange;
          w_driveBus = bus.oe;
        end
        REQ_WRITE: begin
          w_err   = !w_inRange;
          w_memWe = w_inRange;
        end
        REQ_ILLEGAL: begin
          w_err = 1'b1;
        end
        default: begin
          w_err = 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = w_ready;
  assign bus.err   = w_err;

  mem_responder_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk      (clk),
    .i_we     (w_memWe),
    .i_wrIdx  (r_reqAddr[IDX_W-1:0]),
    .i_wrData (r_reqData),
    .i_rdIdx  (r_reqAddr[IDX_W-1:0]),
    .o_rdData (w_memRdData)
  );

  assign w_rdValue = w_inRange ? w_memRdData : '0;
  assign data      = w_driveBus ? w_rdValue : 'z;

`ifdef MEM_RESPONDER_STATS_EN
  logic w_goodRead;
  logic w_goodWrite;

  assign w_goodRead  = w_ready && (r_reqKind == REQ_READ)  && !w_err;
  assign w_goodWrite = w_ready && (r_reqKind == REQ_WRITE) && !w_err;

  // Saturating completion counters for successful reads and writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (w_goodRead && (rd_count != 16'hFFFF))  rd_count <= rd_count + 16'd1;
      if (w_goodWrite && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable bus-side memory target for the CPU's cs/we/oe/address/bidirectional-data memory interface.
- Owns word storage and answers reads and writes issued by the fetch/execute controller.
- Adds configurable wait states and an explicit ready/err handshake, so the CPU stops relying on fixed cycle counts.
- Drives the shared data bus only while returning read data; otherwise high-Z.

Parameters:
- ADDR_WIDTH, 14: address bus width.
- DATA_WIDTH, 32: data word width.
- DEPTH, 1024: number of implemented words; addresses >= DEPTH are out of range.
- WAIT_CYCLES, 1: extra cycles between accept and response (0..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- addr  in  ADDR_WIDTH  word address (MAR).
- data  inout  DATA_WIDTH  shared data bus.
- cs  in  1  chip select; request valid while high.
- we  in  1  write request.
- oe  in  1  read request and output enable.
- ready  out  1  one-cycle completion strobe.
- err  out  1  one-cycle error strobe; coincident with ready.

Behaviour:
- Reset: state IDLE, ready=0, err=0, data high-Z, wait counter=0. Memory contents are not cleared.
- Request decode, sampled only in IDLE or HOLD:
  - READ = cs & oe & ~we.
  - WRITE = cs & we & ~oe.
  - ILLEGAL = cs & we & oe.
  - cs=0 is no request.
- FSM states: IDLE, WAIT, RESP, HOLD.
- IDLE, on READ or WRITE:
  - Latch addr, direction, and (for writes) data into a request register.
  - Load counter with WAIT_CYCLES.
  - Next state is WAIT, or RESP when WAIT_CYCLES=0.
- WAIT: counter decrements each edge; go to RESP when the counter reaches 1.
- WAIT, cs dropping: abort. Return to IDLE with no memory write, no ready, no err.
- RESP lasts exactly one cycle:
  - ready=1.
  - Read: data bus driven with mem[latched addr] while oe=1.
  - Write: mem[latched addr] <= latched data on the edge leaving RESP.
  - Next state HOLD.
- HOLD:
  - Stays while cs=1 with unchanged addr/we/oe; this prevents re-executing a held request.
  - A differing valid request is accepted directly, exactly as from IDLE.
  - cs=0 returns to IDLE.
- Latency, read, from the accept edge E0: data valid and ready high in the cycle after edge E0+WAIT_CYCLES. The initiator samples data at the following edge.
- ILLEGAL: no memory access. Go straight to RESP with ready=1, err=1; data stays high-Z.
- Out of range (latched addr >= DEPTH):
  - Normal timing, err=1 with ready.
  - Read drives all zeros; write is dropped.
- Reset during WAIT/RESP: immediate IDLE, bus released, pending write discarded.
- Width rule: storage index is addr[clog2(DEPTH)-1:0] after the range check; no aliasing.

Optional Feature:
- Macro: MEM_RESPONDER_STATS_EN.
- Defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0].
  - Each counter increments on every completed non-error read or write (the RESP cycle), saturates at 16'hFFFF, and clears on rst.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package mem_bus_pkg:
  - State enum mem_state_t {IDLE, WAIT, RESP, HOLD}.
  - Request-kind enum {REQ_NONE, REQ_READ, REQ_WRITE, REQ_ILLEGAL}.
  - Default width constants.
- Sub-module mem_responder_array: the storage array with one synchronous write port and one asynchronous read port, instantiated once.

Test Plan:
- Write program word 'h1000011E to addr 'h100, then 'h00000120 to 'h102, WAIT_CYCLES=1; read 'h100 and 'h102 back -> data='h1000011E, then 'h00000120, one ready pulse each, err=0.
- WAIT_CYCLES=0, read 'h104 after writing 'h1800011C -> ready and valid data in the cycle immediately after accept.
- Hold cs/oe/addr='h100 for 6 cycles after ready -> exactly one ready pulse. Then change addr to 'h102 without dropping cs -> second ready, data='h00000120.
- Drop cs during WAIT of a write ('h106 <= 'hDEADBEEF, WAIT_CYCLES=3) -> no ready; a later read of 'h106 returns the prior value.
- Read addr 'h3FFF (DEPTH=1024) -> ready=1, err=1, data=0. Request with we=oe=1 -> err=1, memory unchanged, bus high-Z.
- Assert rst mid-read -> ready=0, data high-Z within the same cycle, state IDLE. With MEM_RESPONDER_STATS_EN, after 3 good reads and 2 writes -> rd_count=3, wr_count=2.
